uart_tx_feeder: RTL and testbench

//   Buffered front-end for uart_tx. A host pushes bytes into an internal FIFO at clock rate.
//   A control FSM pops one byte at a time, pulses tx_start with the byte on tx_data, and waits
//   for uart_tx's tx_done_tick. It then observes an optional inter-frame gap and sends the next byte.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_feeder_if.sv | 30 +++
 rtl/uart_sync_fifo.sv | 69 ++++++
 rtl/uart_tx_feeder.sv | 87 ++++++++
 tb/tb_uart_tx_feeder.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit feeder: payload width default and FSM state codes.
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // Width of a down-counter that must hold the value n (never narrower than 1 bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Host write port plus uart_tx handshake for the feeder, with host-side and feeder-side views.
interface uart_tx_feeder_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int DEPTH_LOG2 = 4
);

  logic                  wr_en;
  logic [DATA_BITS-1:0]  wr_data;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  busy;
  logic                  tx_start;
  logic [DATA_BITS-1:0]  tx_data;
  logic                  tx_done_tick;

  modport master (
    output wr_en, wr_data, tx_done_tick,
    input  full, empty, count, overflow, busy, tx_start, tx_data
  );

  modport slave (
    input  wr_en, wr_data, tx_done_tick,
    output full, empty, count, overflow, busy, tx_start, tx_data
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy flags and a one-cycle overflow pulse.
module uart_sync_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_BITS-1:0]  wr_data,
  input  logic                  rd_en,
  output logic [DATA_BITS-1:0]  rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [DATA_BITS-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic                  push;
  logic                  pop;

  // Gating on the registered full means a write while full is dropped even if a pop frees a slot.
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count    <= count_nxt;
      full     <= (count_nxt == CNT_FULL);
      empty    <= (count_nxt == '0);
      overflow <= wr_en && full;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffered front-end for uart_tx: queues host bytes and hands them out one frame at a time.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int DEPTH_LOG2 = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_feeder_if.slave bus
);

  localparam int GW = cnt_width(GAP_CYCLES);

  logic [1:0]            state;
  logic [GW-1:0]         gap_cnt;
  logic                  pop;
  logic [DATA_BITS-1:0]  head;
  logic                  tx_start_q;
  logic [DATA_BITS-1:0]  tx_data_q;

  // Pop combinationally in IDLE so the head byte is latched into tx_data on the same edge.
  assign pop = (state == ST_IDLE) && !bus.empty;

  uart_sync_fifo #(
    .DATA_BITS  (DATA_BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_data  (bus.wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (bus.full),
    .empty    (bus.empty),
    .count    (bus.count),
    .overflow (bus.overflow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      gap_cnt    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!bus.empty) begin
            tx_data_q  <= head;
            tx_start_q <= 1'b1;
            state      <= ST_START;
          end
        end
        ST_START: state <= ST_WAIT;
        ST_WAIT: begin
          if (bus.tx_done_tick) begin
            if (GAP_CYCLES == 0) begin
              state <= ST_IDLE;
            end else begin
              gap_cnt <= GW'(GAP_CYCLES);
              state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          // The last gap cycle is the one where the counter reads 1.
          if (gap_cnt < GW'(2)) begin
            gap_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != ST_IDLE);
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder; small behavioural uart_tx stand-ins answer tx_start with tx_done_tick.
module tb_uart_tx_feeder;

  localparam int DB    = 8;
  localparam int DL    = 4;
  localparam int FRAME = 4;

  typedef struct {
    logic       wr;
    logic [7:0] data;
    int         cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       busy;
    logic       start;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_feeder_if #(.DATA_BITS(DB), .DEPTH_LOG2(DL)) if0 ();
  uart_tx_feeder_if #(.DATA_BITS(DB), .DEPTH_LOG2(DL)) if5 ();

  uart_tx_feeder #(.DATA_BITS(DB), .DEPTH_LOG2(DL), .GAP_CYCLES(0)) dut0 (
    .clk (clk), .rst (rst), .bus (if0.slave)
  );
  uart_tx_feeder #(.DATA_BITS(DB), .DEPTH_LOG2(DL), .GAP_CYCLES(5)) dut5 (
    .clk (clk), .rst (rst), .bus (if5.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // uart_tx stand-in for dut0: logs each frame, answers with tx_done_tick FRAME cycles later
  // (only while auto_en0), and can inject spurious ticks on request.
  logic [7:0] rx0[$];
  int cnt_q[$];
  int start_cyc0[$];
  int tick_cyc0[$];
  int starts0 = 0;
  bit auto_en0 = 1'b0;
  bit spur_now = 1'b0;
  bit spur_at_start = 1'b0;
  int left0 = 0;
  bit pend0 = 1'b0;

  initial begin
    if0.tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      if0.tx_done_tick = 1'b0;
      if (rst) begin
        pend0 = 1'b0;
        left0 = 0;
      end else if (if0.tx_start) begin
        rx0.push_back(if0.tx_data);
        cnt_q.push_back(int'(if0.count));
        start_cyc0.push_back(cyc);
        starts0++;
        pend0 = 1'b1;
        left0 = FRAME;
        if (spur_at_start) begin
          if0.tx_done_tick = 1'b1;
          spur_at_start = 1'b0;
        end
      end else if (spur_now) begin
        if0.tx_done_tick = 1'b1;
        spur_now = 1'b0;
      end else if (pend0) begin
        if (left0 > 0) left0--;
        else if (auto_en0) begin
          if0.tx_done_tick = 1'b1;
          pend0 = 1'b0;
          tick_cyc0.push_back(cyc);
        end
      end
    end
  end

  // uart_tx stand-in for dut5: always answers.
  logic [7:0] rx5[$];
  int start_cyc5[$];
  int tick_cyc5[$];
  int left5 = 0;
  bit pend5 = 1'b0;

  initial begin
    if5.tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      if5.tx_done_tick = 1'b0;
      if (rst) begin
        pend5 = 1'b0;
        left5 = 0;
      end else if (if5.tx_start) begin
        rx5.push_back(if5.tx_data);
        start_cyc5.push_back(cyc);
        pend5 = 1'b1;
        left5 = FRAME;
      end else if (pend5) begin
        if (left5 > 0) left5--;
        else begin
          if5.tx_done_tick = 1'b1;
          pend5 = 1'b0;
          tick_cyc5.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vec[21];
  int   n;
  int   snap;

  initial begin
    // Table: write 0x41 into idle feeder, then fill to full with 0x10..0x1F while the
    // first frame stays unfinished, then a write while full.
    vec[0] = '{1'b1, 8'h41, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[1] = '{1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[2] = '{1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 1; k <= 16; k++)
      vec[2 + k] = '{1'b1, 8'(8'h0F + k), k, (k == 16), 1'b0, 1'b0, 1'b1, 1'b0};
    vec[19] = '{1'b1, 8'hEE, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vec[20] = '{1'b0, 8'h00, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    if0.wr_en = 1'b0; if0.wr_data = '0;
    if5.wr_en = 1'b0; if5.wr_data = '0;

    // Reset state
    #5 rst = 1'b1;
    #100;
    check("rst empty", if0.empty, 1);
    check("rst count", if0.count, 0);
    check("rst tx_start", if0.tx_start, 0);
    check("rst busy", if0.busy, 0);
    check("rst tx_data", if0.tx_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst empty", if0.empty, 1);
    check("post-rst full", if0.full, 0);
    check("post-rst overflow", if0.overflow, 0);

    // Table-driven single write, latency, fill and overflow
    for (int i = 0; i < 21; i++) begin
      if0.wr_en   = vec[i].wr;
      if0.wr_data = vec[i].data;
      @(negedge clk);
      check($sformatf("v%0d count", i), if0.count, vec[i].cnt);
      check($sformatf("v%0d full", i), if0.full, vec[i].full);
      check($sformatf("v%0d empty", i), if0.empty, vec[i].empty);
      check($sformatf("v%0d overflow", i), if0.overflow, vec[i].ovf);
      check($sformatf("v%0d busy", i), if0.busy, vec[i].busy);
      check($sformatf("v%0d tx_start", i), if0.tx_start, vec[i].start);
    end
    if0.wr_en = 1'b0;
    check("held tx_data in WAIT", if0.tx_data, 8'h41);

    // Let frames complete; write while full in the same cycle as a pop
    auto_en0 = 1'b1;
    n = 0;
    while (if0.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy falls after done", n < 100, 1);
    check("full before pop", if0.count, 16);
    if0.wr_en = 1'b1; if0.wr_data = 8'hEF;
    @(negedge clk);
    if0.wr_en = 1'b0;
    check("pop+full overflow", if0.overflow, 1);
    check("pop+full count", if0.count, 15);
    check("pop+full tx_start", if0.tx_start, 1);
    @(negedge clk);
    check("overflow one cycle", if0.overflow, 0);

    n = 0;
    while (!(rx0.size() == 17 && !if0.busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("burst drained in time", n < 400, 1);
    check("frames sent", rx0.size(), 17);
    if (rx0.size() == 17) begin
      check("byte 0", rx0[0], 8'h41);
      for (int j = 1; j < 17; j++) begin
        check($sformatf("byte %0d", j), rx0[j], 8'(8'h0F + j));
        check($sformatf("count at start %0d", j), cnt_q[j], 16 - j);
      end
      for (int j = 0; j < 16; j++)
        check($sformatf("b2b gap %0d", j), start_cyc0[j + 1] - tick_cyc0[j], 2);
    end
    check("drained empty", if0.empty, 1);
    check("drained count", if0.count, 0);
    check("drained busy", if0.busy, 0);

    // Spurious tx_done_tick in IDLE and in START
    rx0.delete();
    snap = starts0;
    spur_now = 1'b1;
    repeat (4) @(negedge clk);
    check("spur idle busy", if0.busy, 0);
    check("spur idle empty", if0.empty, 1);
    check("spur idle starts", starts0, snap);
    spur_at_start = 1'b1;
    if0.wr_en = 1'b1; if0.wr_data = 8'h33;
    @(negedge clk);
    if0.wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("spur start still busy", if0.busy, 1);
    check("spur start tx_data", if0.tx_data, 8'h33);
    n = 0;
    while (if0.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("spur frame done", n < 50, 1);
    check("spur starts", starts0, snap + 1);
    check("spur rx size", rx0.size(), 1);
    if (rx0.size() == 1) check("spur rx byte", rx0[0], 8'h33);

    // Asynchronous reset in mid-frame
    if0.wr_en = 1'b1; if0.wr_data = 8'h77;
    @(negedge clk);
    if0.wr_data = 8'h78;
    @(negedge clk);
    if0.wr_en = 1'b0;
    check("pre-rst tx_start", if0.tx_start, 1);
    #3 rst = 1'b1;
    #1;
    check("async rst empty", if0.empty, 1);
    check("async rst count", if0.count, 0);
    check("async rst tx_start", if0.tx_start, 0);
    check("async rst busy", if0.busy, 0);
    check("async rst tx_data", if0.tx_data, 0);
    @(negedge clk);
    rst = 1'b0;
    snap = starts0;
    repeat (10) @(negedge clk);
    check("no replay starts", starts0, snap);
    check("no replay empty", if0.empty, 1);

    // Inter-frame gap of 5 on dut5
    if5.wr_en = 1'b1; if5.wr_data = 8'hA5;
    @(negedge clk);
    if5.wr_data = 8'h5A;
    @(negedge clk);
    if5.wr_en = 1'b0;
    n = 0;
    while (!(rx5.size() == 2 && !if5.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("gap frames in time", n < 200, 1);
    check("gap rx size", rx5.size(), 2);
    if (rx5.size() == 2 && tick_cyc5.size() >= 1) begin
      check("gap byte 0", rx5[0], 8'hA5);
      check("gap byte 1", rx5[1], 8'h5A);
      check("gap spacing", start_cyc5[1] - tick_cyc5[0], 7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
